down_counter_nbits: RTL

DOWN_COUNTER_NBITS -- requirements
Module: down_counter_nbits

---
 rtl/down_counter_nbits.sv | 86 ++++++++
 1 files changed

// File: rtl/down_counter_nbits.sv
// Loadable down counter with one-shot / auto-reload modes, a registered
// terminal-count pulse and a sticky expiry flag for one-shot completion.
module down_counter_nbits #(
  parameter int nBits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [nBits-1:0] loadValue,
  input  logic             en,
  input  logic             autoReload,
  output logic [nBits-1:0] counter,
  output logic             busy,
  output logic             tc,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [nBits-1:0] ONE = nBits'(1);

  state_e           state_q, state_d;
  logic [nBits-1:0] count_q, count_d;
  logic [nBits-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             expired_q, expired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
      expired_q <= expired_d;
    end
  end

  // Priority clr > load > count; tc is a pulse so it defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    expired_d = expired_q;
    if (clr) begin
      state_d   = IDLE;
      count_d   = '0;
      expired_d = 1'b0;
    end else if (load) begin
      count_d   = loadValue;
      reload_d  = loadValue;
      expired_d = 1'b0;
      state_d   = (loadValue != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      // RUN never holds zero, so <= 1 only catches the terminal step.
      if (count_q <= ONE) begin
        tc_d = 1'b1;
        if (autoReload) begin
          count_d = reload_q;
        end else begin
          count_d   = '0;
          state_d   = IDLE;
          expired_d = 1'b1;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  assign counter = count_q;
  assign busy    = (state_q == RUN);
  assign tc      = tc_q;
  assign expired = expired_q;

endmodule
